// File: rtl/axilite_cmd_master.sv
// axilite_cmd_master
//
// Single-outstanding AXI4-Lite initiator. A simple command stream (cmd_*) is
// turned into one AXI4-Lite read or write transaction at a time. Each result is
// returned on a response stream (rsp_*). A saturating error counter tracks
// non-OKAY responses.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/ready            command handshake
//   cmd_write                  1 = write, 0 = read
//   cmd_addr                   byte address, passed through unmodified
//   cmd_wdata, cmd_wstrb       write payload (ignored for reads)
//   rsp_valid/ready            response handshake
//   rsp_write                  echo of cmd_write
//   rsp_rdata                  read data (0 for writes)
//   rsp_resp                   BRESP/RRESP as returned
//   err_cnt                    saturating count of responses with resp != 0
//   m_axilite_*                AXI4-Lite master channels (AW, W, B, AR, R)
//
// Every output is decoded from registered state, so no input-to-output
// combinational path exists.
module axilite_cmd_master #(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [7:0]            err_cnt,

    output logic                  m_axilite_awvalid,
    input  logic                  m_axilite_awready,
    output logic [ADDR_WIDTH-1:0] m_axilite_awaddr,
    output logic [2:0]            m_axilite_awprot,

    output logic                  m_axilite_wvalid,
    input  logic                  m_axilite_wready,
    output logic [31:0]           m_axilite_wdata,
    output logic [3:0]            m_axilite_wstrb,

    input  logic                  m_axilite_bvalid,
    output logic                  m_axilite_bready,
    input  logic [1:0]            m_axilite_bresp,

    output logic                  m_axilite_arvalid,
    input  logic                  m_axilite_arready,
    output logic [ADDR_WIDTH-1:0] m_axilite_araddr,
    output logic [2:0]            m_axilite_arprot,

    input  logic                  m_axilite_rvalid,
    output logic                  m_axilite_rready,
    input  logic [31:0]           m_axilite_rdata,
    input  logic [1:0]            m_axilite_rresp
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWrB,
        StRdAr,
        StRdR,
        StRsp
    } state_e;

    state_e                state_q, state_d;
    logic                  aw_pend_q, aw_pend_d;
    logic                  w_pend_q, w_pend_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  err_inc;

    always_comb begin
        state_d     = state_q;
        aw_pend_d   = aw_pend_q;
        w_pend_d    = w_pend_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        err_cnt_d   = err_cnt_q;
        err_inc     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = StWr;
                    end else begin
                        state_d = StRdAr;
                    end
                end
            end

            StWr: begin
                // AW and W retire independently; the responder may take them in
                // either order or together.
                if (aw_pend_q && m_axilite_awready) begin
                    aw_pend_d = 1'b0;
                end
                if (w_pend_q && m_axilite_wready) begin
                    w_pend_d = 1'b0;
                end
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = StWrB;
                end
            end

            StWrB: begin
                if (m_axilite_bvalid) begin
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axilite_bresp;
                    err_inc     = (m_axilite_bresp != 2'b00);
                    state_d     = StRsp;
                end
            end

            StRdAr: begin
                if (m_axilite_arready) begin
                    state_d = StRdR;
                end
            end

            StRdR: begin
                if (m_axilite_rvalid) begin
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m_axilite_rdata;
                    rsp_resp_d  = m_axilite_rresp;
                    err_inc     = (m_axilite_rresp != 2'b00);
                    state_d     = StRsp;
                end
            end

            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Saturate rather than wrap so a long error burst stays visible.
        if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            aw_pend_q   <= 1'b0;
            w_pend_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            aw_pend_q   <= aw_pend_d;
            w_pend_q    <= w_pend_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_ready         = (state_q == StIdle);

    assign m_axilite_awvalid = (state_q == StWr) && aw_pend_q;
    assign m_axilite_awaddr  = addr_q;
    assign m_axilite_awprot  = 3'b000;

    assign m_axilite_wvalid  = (state_q == StWr) && w_pend_q;
    assign m_axilite_wdata   = wdata_q;
    assign m_axilite_wstrb   = wstrb_q;

    assign m_axilite_bready  = (state_q == StWrB);

    assign m_axilite_arvalid = (state_q == StRdAr);
    assign m_axilite_araddr  = addr_q;
    assign m_axilite_arprot  = 3'b000;

    assign m_axilite_rready  = (state_q == StRdR);

    assign rsp_valid         = (state_q == StRsp);
    assign rsp_write         = rsp_write_q;
    assign rsp_rdata         = rsp_rdata_q;
    assign rsp_resp          = rsp_resp_q;
    assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_axilite_cmd_master.sv
// Testbench for axilite_cmd_master: a small AXI4-Lite RAM responder with
// programmable per-channel latency and forced response codes, a table of
// directed command vectors, and hand-written sequences for response
// back-pressure, error-counter saturation and asynchronous reset.
module tb_axilite_cmd_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  err_cnt;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axilite_cmd_master #(
        .ADDR_WIDTH(16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_wdata         (cmd_wdata),
        .cmd_wstrb         (cmd_wstrb),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_write         (rsp_write),
        .rsp_rdata         (rsp_rdata),
        .rsp_resp          (rsp_resp),
        .err_cnt           (err_cnt),
        .m_axilite_awvalid (awvalid),
        .m_axilite_awready (awready),
        .m_axilite_awaddr  (awaddr),
        .m_axilite_awprot  (awprot),
        .m_axilite_wvalid  (wvalid),
        .m_axilite_wready  (wready),
        .m_axilite_wdata   (wdata),
        .m_axilite_wstrb   (wstrb),
        .m_axilite_bvalid  (bvalid),
        .m_axilite_bready  (bready),
        .m_axilite_bresp   (bresp),
        .m_axilite_arvalid (arvalid),
        .m_axilite_arready (arready),
        .m_axilite_araddr  (araddr),
        .m_axilite_arprot  (arprot),
        .m_axilite_rvalid  (rvalid),
        .m_axilite_rready  (rready),
        .m_axilite_rdata   (rdata),
        .m_axilite_rresp   (rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- Responder model ----------------
    int          aw_lat, w_lat, b_lat, ar_lat, r_lat;
    logic [1:0]  force_resp;
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic        aw_got, w_got, r_pend;
    logic [15:0] wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [31:0] mem [0:15];
    int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        aw_hold, w_hold, ar_hold;
    int          drops;

    assign awready = awvalid && !aw_got && (aw_wait >= aw_lat);
    assign wready  = wvalid && !w_got && (w_wait >= w_lat);
    assign arready = arvalid && !r_pend && !rvalid && (ar_wait >= ar_lat);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            wr_addr <= '0; rd_addr <= '0; wr_data <= '0; wr_strb <= '0;
            bvalid <= 1'b0; bresp <= '0; rvalid <= 1'b0; rresp <= '0; rdata <= '0;
            aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
            for (int k = 0; k < 16; k++) mem[k] <= '0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;

            if (awvalid && awready) begin
                aw_got  <= 1'b1;
                wr_addr <= awaddr;
                aw_hs   <= aw_hs + 1;
            end
            if (wvalid && wready) begin
                w_got   <= 1'b1;
                wr_data <= wdata;
                wr_strb <= wstrb;
                w_hs    <= w_hs + 1;
            end
            if (aw_got && w_got && !bvalid) begin
                if (b_wait >= b_lat) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) mem[wr_addr[5:2]][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                    bvalid <= 1'b1;
                    bresp  <= force_resp;
                    aw_got <= 1'b0;
                    w_got  <= 1'b0;
                    b_wait <= 0;
                end else begin
                    b_wait <= b_wait + 1;
                end
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                b_hs   <= b_hs + 1;
            end

            if (arvalid && arready) begin
                r_pend  <= 1'b1;
                rd_addr <= araddr;
                r_wait  <= 0;
                ar_hs   <= ar_hs + 1;
            end
            if (r_pend && !rvalid) begin
                if (r_wait >= r_lat) begin
                    rvalid <= 1'b1;
                    rdata  <= mem[rd_addr[5:2]];
                    rresp  <= force_resp;
                    r_pend <= 1'b0;
                end else begin
                    r_wait <= r_wait + 1;
                end
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0;
                r_hs   <= r_hs + 1;
            end

            // A valid that was waiting must still be up on the next edge.
            aw_hold <= awvalid && !awready;
            w_hold  <= wvalid && !wready;
            ar_hold <= arvalid && !arready;
            if ((aw_hold && !awvalid) || (w_hold && !wvalid) || (ar_hold && !arvalid)) begin
                drops <= drops + 1;
            end
        end
    end

    // ---------------- Checking ----------------
    int n_vec;
    int n_miss;
    int exp_err;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_cmd(input logic w, input logic [15:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        bit got;
        got       = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        for (int i = 0; i < 50 && !got; i++) begin
            if (cmd_ready) got = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("cmd_accept", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_rsp();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            if (rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
        check("rsp_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_lat;
        int          w_lat;
        int          lat;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int aw0, w0, b0, ar0, r0;
        aw_lat = v.aw_lat; w_lat = v.w_lat; ar_lat = v.aw_lat;
        b_lat  = v.lat;    r_lat = v.lat;   force_resp = v.resp;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
        send_cmd(v.wr, v.addr, v.wdata, v.strb);
        check("valid_rise", {29'd0, awvalid, wvalid, arvalid}, v.wr ? 32'd6 : 32'd1);
        check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        wait_rsp();
        check("rsp_write", {31'd0, rsp_write}, {31'd0, v.wr});
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("rsp_resp", {30'd0, rsp_resp}, {30'd0, v.resp});
        if (v.resp != 2'b00 && exp_err < 255) exp_err++;
        check("err_cnt", {24'd0, err_cnt}, exp_err);
        take_rsp();
        check("handshakes", {27'd0, 1'(aw_hs - aw0), 1'(w_hs - w0), 1'(b_hs - b0),
                             1'(ar_hs - ar0), 1'(r_hs - r0)},
              v.wr ? 32'b11100 : 32'b00011);
    endtask

    vec_t vecs [8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        n_vec = 0; n_miss = 0; exp_err = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; drops = 0;
        aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0; force_resp = 2'b00;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;

        //          wr    addr      wdata         strb  awl wl lat resp   exp_rdata
        vecs[0] = '{1'b1, 16'h0000, 32'h0010029b, 4'hF, 0,  2, 0,  2'b00, 32'h00000000};
        vecs[1] = '{1'b0, 16'h0000, 32'h0,        4'h0, 0,  0, 3,  2'b00, 32'h0010029b};
        vecs[2] = '{1'b1, 16'h0004, 32'hAABBCCDD, 4'h5, 0,  0, 0,  2'b00, 32'h00000000};
        vecs[3] = '{1'b0, 16'h0004, 32'h0,        4'h0, 1,  0, 0,  2'b00, 32'h00BB00DD};
        vecs[4] = '{1'b1, 16'h0008, 32'h12345678, 4'hF, 3,  0, 2,  2'b10, 32'h00000000};
        vecs[5] = '{1'b0, 16'h0008, 32'h0,        4'h0, 2,  0, 1,  2'b11, 32'h12345678};
        vecs[6] = '{1'b1, 16'h000C, 32'hDEADBEEF, 4'hC, 1,  1, 1,  2'b00, 32'h00000000};
        vecs[7] = '{1'b0, 16'h000C, 32'h0,        4'h0, 0,  0, 0,  2'b00, 32'hDEAD0000};

        rst_n = 1'b0;
        #3;
        check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset_valids", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid},
              32'd0);
        check("reset_rsp", {rsp_write, rsp_rdata[30:0]}, 32'd0);
        check("reset_resp_err", {22'd0, rsp_rdata[31], rsp_resp, err_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Response back-pressure: fields hold and no new command is taken.
        aw_lat = 0; w_lat = 0; ar_lat = 0; b_lat = 0; r_lat = 1; force_resp = 2'b00;
        send_cmd(1'b0, 16'h0004, 32'h0, 4'h0);
        wait_rsp();
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, 32'h00BB00DD);
            check("hold_fields", {29'd0, rsp_write, rsp_resp}, 32'd0);
            check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        take_rsp();
        check("ready_after_rsp", {31'd0, cmd_ready}, 32'd1);
        v = '{1'b0, 16'h0008, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h12345678};
        run_vec(v);

        // Asynchronous reset in the middle of a write with AW and W both pending.
        aw_lat = 30; w_lat = 30; b_lat = 0;
        send_cmd(1'b1, 16'h0010, 32'h55AA55AA, 4'hF);
        @(negedge clk);
        check("pre_reset_valids", {30'd0, awvalid, wvalid}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_valids", {29'd0, awvalid, wvalid, rsp_valid}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{1'b0, 16'h0000, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h00000000};
        run_vec(v);

        // 300 SLVERR reads: counter steps once per response, then saturates.
        v = '{1'b0, 16'h0000, 32'h0, 4'h0, 0, 0, 0, 2'b10, 32'h00000000};
        for (int i = 0; i < 300; i++) run_vec(v);
        check("err_saturated", {24'd0, err_cnt}, 32'd255);

        check("valid_drops", drops, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
